// File: rtl/tt_sram_byte_bridge.sv
// ----------------------------------------------------------------------------
// tt_sram_byte_bridge
//   Bridges a byte-wide valid/ready request port onto a WORD_BYTES-wide
//   OpenRAM-style single-port (1RW) macro. It supports:
//   - byte-lane write masking;
//   - a configurable macro read latency;
//   - an auto-incrementing byte pointer for burst streaming;
//   - a one-cycle response pulse for every completed request.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   req_valid/ready     request handshake (ready only when idle, not in reset)
//   req_we              1 = write byte, 0 = read byte
//   req_inc             1 = use addr_ptr, 0 = use req_addr
//   req_addr/req_wdata  byte address and write byte
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           last read byte, held until the next read completes
//   addr_ptr            auto-increment byte pointer
//   ram_*               macro port (clk0/csb0/web0/wmask0/addr0/din0/dout0)
// ----------------------------------------------------------------------------
module tt_sram_byte_bridge #(
  parameter  int WORD_BYTES = 4,
  parameter  int RAM_AW     = 9,
  parameter  int READ_LAT   = 1,
  localparam int LB         = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 0,
  localparam int ADDR_W     = RAM_AW + LB
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic                    req_inc,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [7:0]              req_wdata,
  output logic                    rsp_valid,
  output logic [7:0]              rsp_rdata,
  output logic [ADDR_W-1:0]       addr_ptr,
  output logic                    ram_clk0,
  output logic                    ram_csb0,
  output logic                    ram_web0,
  output logic [WORD_BYTES-1:0]   ram_wmask0,
  output logic [RAM_AW-1:0]       ram_addr0,
  output logic [8*WORD_BYTES-1:0] ram_din0,
  input  logic [8*WORD_BYTES-1:0] ram_dout0
);

  localparam int LANE_W = (LB > 0) ? LB : 1;
  localparam int CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t              state, state_next;
  logic                accept;
  logic [ADDR_W-1:0]   eff_addr;
  logic [RAM_AW-1:0]   eff_word;
  logic [LANE_W-1:0]   eff_lane;
  logic                we_p0;
  logic [LANE_W-1:0]   lane_p0;
  logic [CNT_W-1:0]    wait_cnt;
  logic                last_wait;
  logic                csb_next;
  logic                web_next;
  logic [WORD_BYTES-1:0] wmask_next;
  logic                rsp_next;
  logic                capture;
  logic [7:0]          rd_byte;

  assign ram_clk0  = clk;
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign eff_addr  = req_inc ? addr_ptr : req_addr;
  assign last_wait = (wait_cnt == CNT_W'(READ_LAT - 1));

  // A single-byte word has no lane field; the whole byte address is the word.
  generate
    if (LB > 0) begin : g_lane
      assign eff_word = eff_addr[ADDR_W-1:LB];
      assign eff_lane = eff_addr[LB-1:0];
    end else begin : g_nolane
      assign eff_word = eff_addr;
      assign eff_lane = '0;
    end
  endgenerate

  // Lane select of the macro read word, using the lane latched at accept.
  always_comb begin
    rd_byte = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (LANE_W'(b) == lane_p0) rd_byte = ram_dout0[8*b +: 8];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = we_p0 ? IDLE : WAIT;
      WAIT:    if (last_wait) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: macro strobes are registered, so they are derived from
  // the state being entered and become visible for exactly the ACCESS cycle.
  always_comb begin
    csb_next   = 1'b1;
    web_next   = 1'b1;
    wmask_next = '0;
    rsp_next   = 1'b0;
    capture    = 1'b0;
    if (state_next == ACCESS) begin
      csb_next   = 1'b0;
      web_next   = !req_we;
      wmask_next = req_we ? (WORD_BYTES'(1) << eff_lane) : '1;
    end
    if (state == ACCESS && we_p0) rsp_next = 1'b1;
    if (state == WAIT && last_wait) begin
      rsp_next = 1'b1;
      capture  = 1'b1;
    end
  end

  // p0: request capture at accept, macro port registers, response
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_csb0   <= 1'b1;
      ram_web0   <= 1'b1;
      ram_wmask0 <= '0;
      ram_addr0  <= '0;
      ram_din0   <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      addr_ptr   <= '0;
      we_p0      <= 1'b0;
      lane_p0    <= '0;
      wait_cnt   <= '0;
    end else begin
      ram_csb0   <= csb_next;
      ram_web0   <= web_next;
      ram_wmask0 <= wmask_next;
      rsp_valid  <= rsp_next;
      if (accept) begin
        ram_addr0 <= eff_word;
        ram_din0  <= {WORD_BYTES{req_wdata}};
        addr_ptr  <= eff_addr + ADDR_W'(1);
        we_p0     <= req_we;
        lane_p0   <= eff_lane;
      end
      if (capture) rsp_rdata <= rd_byte;
      if (state == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      else               wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_tt_sram_byte_bridge.sv
// ----------------------------------------------------------------------------
// tb_tt_sram_byte_bridge
//   Directed bench for two bridge configurations:
//   - u_dut0: WORD_BYTES=4, READ_LAT=1 (ADDR_W=11);
//   - u_dut1: WORD_BYTES=1, READ_LAT=2 (ADDR_W=9).
//   Each instance drives a behavioural 1RW macro model. Expected responses
//   go to a scoreboard queue at accept and are popped when rsp_valid pulses.
// ----------------------------------------------------------------------------
module tb_tt_sram_byte_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0 signals
  logic        rv0 = 0, we0 = 0, inc0 = 0;
  logic [10:0] ai0 = '0;
  logic [7:0]  wd0 = '0;
  logic        rdy0, rspv0, rclk0, csb0, web0;
  logic [7:0]  rd0;
  logic [10:0] ptr0;
  logic [3:0]  wm0;
  logic [8:0]  ra0;
  logic [31:0] din0, dout0;

  // instance 1 signals
  logic        rv1 = 0, we1 = 0, inc1 = 0;
  logic [8:0]  ai1 = '0;
  logic [7:0]  wd1 = '0;
  logic        rdy1, rspv1, rclk1, csb1, web1;
  logic [7:0]  rd1;
  logic [8:0]  ptr1;
  logic [0:0]  wm1;
  logic [8:0]  ra1;
  logic [7:0]  din1, dout1;

  tt_sram_byte_bridge #(.WORD_BYTES(4), .RAM_AW(9), .READ_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_we(we0),
    .req_inc(inc0), .req_addr(ai0), .req_wdata(wd0), .rsp_valid(rspv0),
    .rsp_rdata(rd0), .addr_ptr(ptr0), .ram_clk0(rclk0), .ram_csb0(csb0),
    .ram_web0(web0), .ram_wmask0(wm0), .ram_addr0(ra0), .ram_din0(din0),
    .ram_dout0(dout0));

  tt_sram_byte_bridge #(.WORD_BYTES(1), .RAM_AW(9), .READ_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_we(we1),
    .req_inc(inc1), .req_addr(ai1), .req_wdata(wd1), .rsp_valid(rspv1),
    .rsp_rdata(rd1), .addr_ptr(ptr1), .ram_clk0(rclk1), .ram_csb0(csb1),
    .ram_web0(web1), .ram_wmask0(wm1), .ram_addr0(ra1), .ram_din0(din1),
    .ram_dout0(dout1));

  // Behavioural macros: sample on the edge that ends the select cycle.
  logic [31:0] mem0 [512];
  logic [7:0]  mem1 [512];

  always @(posedge rclk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wm0[b]) mem0[ra0][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        dout0 <= mem0[ra0];
      end
    end
  end

  always @(posedge rclk1) begin
    if (!csb1) begin
      if (!web1) begin
        if (wm1[0]) mem1[ra1] <= din1;
      end else begin
        dout1 <= mem1[ra1];
      end
    end
  end

  // Bench state
  int errors = 0;
  int checks = 0;

  typedef struct { logic [7:0] rdata; int lat; } exp_t;
  exp_t sb[$];

  logic [10:0] ptr_m [2];
  logic [7:0]  last_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] f_rdy(input int sel);  return sel != 0 ? 32'(rdy1)  : 32'(rdy0);  endfunction
  function automatic logic [31:0] f_rspv(input int sel); return sel != 0 ? 32'(rspv1) : 32'(rspv0); endfunction
  function automatic logic [31:0] f_rd(input int sel);   return sel != 0 ? 32'(rd1)   : 32'(rd0);   endfunction
  function automatic logic [31:0] f_csb(input int sel);  return sel != 0 ? 32'(csb1)  : 32'(csb0);  endfunction
  function automatic logic [31:0] f_web(input int sel);  return sel != 0 ? 32'(web1)  : 32'(web0);  endfunction
  function automatic logic [31:0] f_wm(input int sel);   return sel != 0 ? 32'(wm1)   : 32'(wm0);   endfunction
  function automatic logic [31:0] f_ra(input int sel);   return sel != 0 ? 32'(ra1)   : 32'(ra0);   endfunction
  function automatic logic [31:0] f_din(input int sel);  return sel != 0 ? 32'(din1)  : din0;       endfunction
  function automatic logic [31:0] f_ptr(input int sel);  return sel != 0 ? 32'(ptr1)  : 32'(ptr0);  endfunction

  task automatic drive(input int sel, input bit v, input bit w, input bit i,
                       input logic [10:0] a, input logic [7:0] d);
    if (sel == 0) begin
      rv0 = v; we0 = w; inc0 = i; ai0 = a; wd0 = d;
    end else begin
      rv1 = v; we1 = w; inc1 = i; ai1 = a[8:0]; wd1 = d;
    end
  endtask

  // One request: handshake, ACCESS-cycle port checks, response via scoreboard.
  // With hold=1, req_valid stays high while the bridge is busy.
  task automatic do_req(input int sel, input bit we, input bit inc,
                        input logic [10:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input bit hold);
    logic [10:0] mask, eff;
    logic [31:0] ewm, edin;
    int lb, lat, ncs;
    bit got;
    exp_t e, p;
    mask = (sel != 0) ? 11'h1FF : 11'h7FF;
    lb   = (sel != 0) ? 0 : 2;
    eff  = (inc ? ptr_m[sel] : addr) & mask;
    drive(sel, 1'b1, we, inc, addr, wd);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = f_rdy(sel)[0];
      @(posedge clk); #1;
    end
    chk("accept", 32'(got), 32'd1);
    if (!got) begin
      drive(sel, 1'b0, 1'b0, 1'b0, 11'h0, 8'h0);
      return;
    end
    ptr_m[sel] = (eff + 11'd1) & mask;
    e.rdata = we ? last_rd[sel] : exp_rd;
    e.lat   = we ? 1 : ((sel != 0) ? 3 : 2);
    sb.push_back(e);
    if (!we) last_rd[sel] = exp_rd;
    if (!hold) drive(sel, 1'b0, 1'b0, 1'b0, 11'h0, 8'h0);

    if (sel != 0) ewm = 32'd1;
    else          ewm = we ? (32'd1 << eff[1:0]) : 32'hF;
    edin = (sel != 0) ? {24'h0, wd} : {4{wd}};
    chk("access_csb0", f_csb(sel), 32'd0);
    chk("access_web0", f_web(sel), 32'(!we));
    chk("access_addr0", f_ra(sel), 32'(eff >> lb));
    chk("access_wmask0", f_wm(sel), ewm);
    chk("access_din0", f_din(sel), edin);
    chk("addr_ptr", f_ptr(sel), 32'(ptr_m[sel]));

    lat = 0; ncs = 1; got = 1'b0;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (f_rspv(sel)[0]) got = 1'b1;
      else if (f_csb(sel) == 32'd0) ncs++;
    end
    chk("rsp_seen", 32'(got), 32'd1);
    if (got) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        p = sb.pop_front();
        chk("rsp_rdata", f_rd(sel), 32'(p.rdata));
        chk("rsp_latency", 32'(lat), 32'(p.lat));
      end
      chk("idle_csb0", f_csb(sel), 32'd1);
      chk("idle_wmask0", f_wm(sel), 32'd0);
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 11'h0, 8'h0);
    chk("single_access", 32'(ncs), 32'd1);
    @(posedge clk); #1;
    chk("rsp_pulse_end", f_rspv(sel), 32'd0);
    chk("no_reaccept", f_csb(sel), 32'd1);
    chk("ptr_stable", f_ptr(sel), 32'(ptr_m[sel]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ptr_m[0] = '0; ptr_m[1] = '0;
    last_rd[0] = '0; last_rd[1] = '0;

    // Reset held two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_csb0", f_csb(s), 32'd1);
      chk("rst_web0", f_web(s), 32'd1);
      chk("rst_wmask0", f_wm(s), 32'd0);
      chk("rst_addr0", f_ra(s), 32'd0);
      chk("rst_din0", f_din(s), 32'd0);
      chk("rst_rsp_valid", f_rspv(s), 32'd0);
      chk("rst_rsp_rdata", f_rd(s), 32'd0);
      chk("rst_addr_ptr", f_ptr(s), 32'd0);
      chk("rst_ready_low", f_rdy(s), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("ready_after_rst0", f_rdy(0), 32'd1);
    chk("ready_after_rst1", f_rdy(1), 32'd1);

    // Single masked write
    do_req(0, 1'b1, 1'b0, 11'h006, 8'hA5, 8'h00, 1'b0);

    // Burst write then burst read back through the pointer
    do_req(0, 1'b1, 1'b0, 11'h000, 8'h11, 8'h00, 1'b0);
    do_req(0, 1'b1, 1'b1, 11'h000, 8'h12, 8'h00, 1'b0);
    do_req(0, 1'b1, 1'b1, 11'h000, 8'h13, 8'h00, 1'b0);
    do_req(0, 1'b1, 1'b1, 11'h000, 8'h14, 8'h00, 1'b0);
    do_req(0, 1'b0, 1'b0, 11'h000, 8'h00, 8'h11, 1'b0);
    do_req(0, 1'b0, 1'b1, 11'h000, 8'h00, 8'h12, 1'b0);
    do_req(0, 1'b0, 1'b1, 11'h000, 8'h00, 8'h13, 1'b0);
    do_req(0, 1'b0, 1'b1, 11'h000, 8'h00, 8'h14, 1'b0);

    // Pointer wrap from the top byte to zero
    do_req(0, 1'b1, 1'b0, 11'h7FF, 8'hEE, 8'h00, 1'b0);
    chk("wrap_ptr", f_ptr(0), 32'd0);
    do_req(0, 1'b0, 1'b1, 11'h000, 8'h00, 8'h11, 1'b0);

    // Reset during the read wait cycle
    drive(0, 1'b1, 1'b0, 1'b0, 11'h002, 8'h00);
    for (int i = 0; i < 20 && !rdy0; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 11'h0, 8'h0);
    chk("midrd_access", f_csb(0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrd_rsp_valid", f_rspv(0), 32'd0);
    chk("midrd_csb0", f_csb(0), 32'd1);
    chk("midrd_rsp_rdata", f_rd(0), 32'd0);
    chk("midrd_addr_ptr", f_ptr(0), 32'd0);
    rst = 1'b0;
    #1;
    ptr_m[0] = '0; ptr_m[1] = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    chk("midrd_ready", f_rdy(0), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrd_no_rsp", f_rspv(0), 32'd0);
    end

    // Single-byte word, two-edge read latency, held request
    do_req(1, 1'b1, 1'b0, 11'h010, 8'h5A, 8'h00, 1'b0);
    do_req(1, 1'b1, 1'b1, 11'h000, 8'h77, 8'h00, 1'b0);
    do_req(1, 1'b0, 1'b0, 11'h010, 8'h00, 8'h5A, 1'b0);
    do_req(1, 1'b0, 1'b1, 11'h000, 8'h00, 8'h77, 1'b1);
    chk("hold_ptr", f_ptr(1), 32'h012);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
